// File: rtl/bpf_biquad_cascade.sv
// rtl/bpf_biquad_cascade.sv - cascade of DF-I biquad sections sharing one MAC, loadable coefficients
// Optional feature macro: BPF_BIQUAD_SAT_EN (saturating narrowing plus sticky sat_flag output).
module bpf_biquad_cascade #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int FRAC   = 14,
   parameter int N_SECT = 2,
   parameter int ACC_W  = DATA_W + COEF_W + 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   input  logic                        cfg_we,
   input  logic [$clog2(5*N_SECT)-1:0] cfg_addr,
   input  logic [COEF_W-1:0]           cfg_data,
   output logic                        cfg_err
`ifdef BPF_BIQUAD_SAT_EN
   ,
   output logic                        sat_flag
`endif
);

   localparam int NCOEF  = 5 * N_SECT;
   localparam int ADDR_W = $clog2(NCOEF);
   localparam int SECT_W = (N_SECT > 1) ? $clog2(N_SECT) : 1;
   localparam int PROD_W = DATA_W + COEF_W;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_MAC    = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   localparam logic signed [ACC_W-1:0]  HALF = ACC_W'(1) << (FRAC - 1);
   localparam logic signed [COEF_W-1:0] ONE  = COEF_W'(1) << FRAC;

   logic [1:0]               state_q, state_d;
   logic                     run_q, run_d;
   logic [SECT_W-1:0]        sect_q, sect_d;
   logic [2:0]               k_q, k_d;
   logic [ADDR_W-1:0]        ci_q, ci_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [DATA_W-1:0] x_q, x_d;
   logic [DATA_W-1:0]        out_data_q, out_data_d;
   logic                     cfg_err_q, cfg_err_d;
   logic signed [COEF_W-1:0] coef_q [NCOEF];
   logic signed [COEF_W-1:0] coef_d [NCOEF];
   logic signed [DATA_W-1:0] x1_q [N_SECT];
   logic signed [DATA_W-1:0] x1_d [N_SECT];
   logic signed [DATA_W-1:0] x2_q [N_SECT];
   logic signed [DATA_W-1:0] x2_d [N_SECT];
   logic signed [DATA_W-1:0] y1_q [N_SECT];
   logic signed [DATA_W-1:0] y1_d [N_SECT];
   logic signed [DATA_W-1:0] y2_q [N_SECT];
   logic signed [DATA_W-1:0] y2_d [N_SECT];
`ifdef BPF_BIQUAD_SAT_EN
   logic                     sat_q, sat_d;
   logic                     y_ovf;
`else
   logic                     unused_hi;
`endif

   logic signed [COEF_W-1:0] mac_coef;
   logic signed [DATA_W-1:0] mac_opnd;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  rnd;
   logic signed [ACC_W-1:0]  y_full;
   logic signed [DATA_W-1:0] y_narrow;
   logic                     cfg_ok;
   logic                     accept;

   // Shared MAC operand selection, product and commit-time rounding/narrowing
   always_comb begin
      mac_coef = coef_q[ci_q];
      case (k_q)
         3'd0:    mac_opnd = x_q;
         3'd1:    mac_opnd = x1_q[sect_q];
         3'd2:    mac_opnd = x2_q[sect_q];
         3'd3:    mac_opnd = y1_q[sect_q];
         default: mac_opnd = y2_q[sect_q];
      endcase
      prod     = mac_coef * mac_opnd;
      prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      rnd      = acc_q + HALF;
      y_full   = rnd >>> FRAC;
`ifdef BPF_BIQUAD_SAT_EN
      // Result fits only if every bit from the DATA_W sign bit upward agrees
      y_ovf = ~((&y_full[ACC_W-1:DATA_W-1]) | ~(|y_full[ACC_W-1:DATA_W-1]));
      if (y_ovf)
         y_narrow = y_full[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else
         y_narrow = y_full[DATA_W-1:0];
`else
      y_narrow  = y_full[DATA_W-1:0];
      unused_hi = ^y_full[ACC_W-1:DATA_W];
`endif
   end

   // Sequencer: handshakes, config writes, history clear and the IDLE/MAC/COMMIT/HOLD flow
   always_comb begin
      state_d    = state_q;
      run_d      = 1'b1;
      sect_d     = sect_q;
      k_d        = k_q;
      ci_d       = ci_q;
      acc_d      = acc_q;
      x_d        = x_q;
      out_data_d = out_data_q;
      coef_d     = coef_q;
      x1_d       = x1_q;
      x2_d       = x2_q;
      y1_d       = y1_q;
      y2_d       = y2_q;
`ifdef BPF_BIQUAD_SAT_EN
      sat_d      = sat_q;
`endif

      // Config writes win over sample intake, and only land while idle
      cfg_ok    = (state_q == S_IDLE) && (32'(cfg_addr) < NCOEF);
      cfg_err_d = cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok)
         coef_d[cfg_addr] = cfg_data;

      in_ready = run_q && !cfg_we &&
                 ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
      accept   = in_valid && in_ready;

      if (clr && (state_q == S_IDLE)) begin
         for (int s = 0; s < N_SECT; s++) begin
            x1_d[s] = '0;
            x2_d[s] = '0;
            y1_d[s] = '0;
            y2_d[s] = '0;
         end
`ifdef BPF_BIQUAD_SAT_EN
         sat_d = 1'b0;
`endif
      end

      case (state_q)
         S_IDLE, S_HOLD: begin
            if ((state_q == S_HOLD) && out_ready)
               state_d = S_IDLE;
            if (accept) begin
               state_d = S_MAC;
               x_d     = in_data;
               sect_d  = '0;
               k_d     = '0;
               ci_d    = '0;
            end
         end
         S_MAC: begin
            if (k_q == 3'd0)
               acc_d = prod_ext;
            else if (k_q >= 3'd3)
               acc_d = acc_q - prod_ext;
            else
               acc_d = acc_q + prod_ext;
            ci_d = ci_q + 1'b1;
            if (k_q == 3'd4) begin
               k_d     = '0;
               state_d = S_COMMIT;
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         S_COMMIT: begin
            x2_d[sect_q] = x1_q[sect_q];
            x1_d[sect_q] = x_q;
            y2_d[sect_q] = y1_q[sect_q];
            y1_d[sect_q] = y_narrow;
            x_d          = y_narrow;
`ifdef BPF_BIQUAD_SAT_EN
            if (y_ovf)
               sat_d = 1'b1;
`endif
            if (sect_q == SECT_W'(N_SECT - 1)) begin
               out_data_d = y_narrow;
               state_d    = S_HOLD;
            end else begin
               sect_d  = sect_q + 1'b1;
               state_d = S_MAC;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset restores passthrough coefficients and empty history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         run_q      <= 1'b0;
         sect_q     <= '0;
         k_q        <= '0;
         ci_q       <= '0;
         acc_q      <= '0;
         x_q        <= '0;
         out_data_q <= '0;
         cfg_err_q  <= 1'b0;
         for (int i = 0; i < NCOEF; i++)
            coef_q[i] <= ((i % 5) == 0) ? ONE : '0;
         for (int s = 0; s < N_SECT; s++) begin
            x1_q[s] <= '0;
            x2_q[s] <= '0;
            y1_q[s] <= '0;
            y2_q[s] <= '0;
         end
`ifdef BPF_BIQUAD_SAT_EN
         sat_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         sect_q     <= sect_d;
         k_q        <= k_d;
         ci_q       <= ci_d;
         acc_q      <= acc_d;
         x_q        <= x_d;
         out_data_q <= out_data_d;
         cfg_err_q  <= cfg_err_d;
         coef_q     <= coef_d;
         x1_q       <= x1_d;
         x2_q       <= x2_d;
         y1_q       <= y1_d;
         y2_q       <= y2_d;
`ifdef BPF_BIQUAD_SAT_EN
         sat_q      <= sat_d;
`endif
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = (state_q == S_HOLD);
   assign cfg_err   = cfg_err_q;
`ifdef BPF_BIQUAD_SAT_EN
   assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_bpf_biquad_cascade.sv
// tb/tb_bpf_biquad_cascade.sv - randomized self-checking bench for bpf_biquad_cascade
module tb_bpf_biquad_cascade;

   localparam int DATA_W = 16;
   localparam int COEF_W = 16;
   localparam int FRAC   = 14;
   localparam int N_SECT = 2;
   localparam int NCOEF  = 5 * N_SECT;
   localparam int ADDR_W = $clog2(NCOEF);
   localparam int LAT    = 6 * N_SECT;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clr = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              cfg_we = 1'b0;
   logic [ADDR_W-1:0] cfg_addr = '0;
   logic [COEF_W-1:0] cfg_data = '0;
   logic              cfg_err;
`ifdef BPF_BIQUAD_SAT_EN
   logic              sat_flag;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   bpf_biquad_cascade #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC(FRAC), .N_SECT(N_SECT)
   ) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err)
`ifdef BPF_BIQUAD_SAT_EN
      , .sat_flag(sat_flag)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model: plain difference equations ----------------
   int     m_coef [NCOEF];
   longint m_x1 [N_SECT];
   longint m_x2 [N_SECT];
   longint m_y1 [N_SECT];
   longint m_y2 [N_SECT];
   bit     m_sat;

   function automatic void model_clear();
      for (int s = 0; s < N_SECT; s++) begin
         m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
      end
      m_sat = 0;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NCOEF; i++) m_coef[i] = ((i % 5) == 0) ? (1 << FRAC) : 0;
      model_clear();
   endfunction

   function automatic longint model_narrow(longint v);
      longint hi = (longint'(1) << (DATA_W - 1)) - 1;
      longint lo = -(longint'(1) << (DATA_W - 1));
`ifdef BPF_BIQUAD_SAT_EN
      if (v > hi) begin m_sat = 1; return hi; end
      if (v < lo) begin m_sat = 1; return lo; end
      return v;
`else
      longint m = longint'(1) << DATA_W;
      longint r = (v - lo) % m;
      if (r < 0) r = r + m;
      return r + lo;
`endif
   endfunction

   function automatic int model_step(int x);
      longint cur = x;
      longint acc;
      longint y;
      for (int s = 0; s < N_SECT; s++) begin
         acc = m_coef[5*s]   * cur     + m_coef[5*s+1] * m_x1[s] + m_coef[5*s+2] * m_x2[s]
             - m_coef[5*s+3] * m_y1[s] - m_coef[5*s+4] * m_y2[s];
         y = model_narrow((acc + (longint'(1) << (FRAC - 1))) >>> FRAC);
         m_x2[s] = m_x1[s]; m_x1[s] = cur;
         m_y2[s] = m_y1[s]; m_y1[s] = y;
         cur = y;
      end
      return int'(cur);
   endfunction

   function automatic int rand_sample();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   // ---------------- stimulus plumbing (no comparisons) ----------------
   task automatic apply_reset();
      rst = 1; clr = 0; in_valid = 0; in_data = '0; out_ready = 0;
      cfg_we = 0; cfg_addr = '0; cfg_data = '0;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      model_reset();
   endtask

   task automatic cfg_write(input int addr, input int val);
      cfg_we = 1; cfg_addr = ADDR_W'(addr); cfg_data = COEF_W'(val);
      @(negedge clk);
      cfg_we = 0;
      if (addr < NCOEF) m_coef[addr] = val;
   endtask

   // Presents x until it is taken; returns at the negedge following the handshake edge
   task automatic start_sample(input int x, input bit with_clr);
      int w = 0;
      in_valid = 1; in_data = DATA_W'(x); clr = with_clr;
      #1;
      while (!in_ready && w < 100) begin
         @(negedge clk); #1; w++;
      end
      @(negedge clk);
      in_valid = 0; clr = 0; in_data = '0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(negedge clk); lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic run_sample(input int x, input bit with_clr, input int stall,
                             output int y, output int lat);
      start_sample(x, with_clr);
      wait_out(lat);
      repeat (stall) @(negedge clk);
      y = int'($signed(out_data));
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1; in_valid = 1; in_data = 16'h1234; out_ready = 1;
      repeat (2) @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (out_data !== '0) $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
      n_checks++; if (cfg_err !== 1'b0) $display("FAIL rst_cfg_err: got %b want 0", cfg_err); else n_pass++;
`ifdef BPF_BIQUAD_SAT_EN
      n_checks++; if (sat_flag !== 1'b0) $display("FAIL rst_sat_flag: got %b want 0", sat_flag); else n_pass++;
`endif
      in_valid = 0; out_ready = 0; in_data = '0;
      rst = 0;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else n_pass++;
      model_reset();
   endtask

   task automatic test_passthrough();
      int xs [2] = '{1234, -5};
      int y, lat, e;
      foreach (xs[i]) begin
         e = model_step(xs[i]);
         run_sample(xs[i], 0, 0, y, lat);
         n_checks++; if (y !== e) $display("FAIL pass_data[%0d]: got %0d want %0d", i, y, e); else n_pass++;
         n_checks++; if (y !== xs[i]) $display("FAIL pass_identity[%0d]: got %0d want %0d", i, y, xs[i]); else n_pass++;
         n_checks++; if (lat !== LAT) $display("FAIL pass_latency[%0d]: got %0d want %0d", i, lat, LAT); else n_pass++;
      end
   endtask

   task automatic test_cfg_busy();
      int lat, y, e;
      start_sample(321, 0);
      @(negedge clk);
      cfg_we = 1; cfg_addr = '0; cfg_data = 16'd8192;
      @(negedge clk);
      cfg_we = 0;
      n_checks++; if (cfg_err !== 1'b1) $display("FAIL busy_cfg_err: got %b want 1", cfg_err); else n_pass++;
      @(negedge clk);
      n_checks++; if (cfg_err !== 1'b0) $display("FAIL busy_cfg_err_pulse: got %b want 0", cfg_err); else n_pass++;
      e = model_step(321);
      wait_out(lat);
      n_checks++; if (int'($signed(out_data)) !== e) $display("FAIL busy_out: got %0d want %0d", $signed(out_data), e); else n_pass++;
      out_ready = 1; @(negedge clk); out_ready = 0;
      e = model_step(-4000);
      run_sample(-4000, 0, 0, y, lat);
      n_checks++; if (y !== e) $display("FAIL busy_readback: got %0d want %0d", y, e); else n_pass++;
   endtask

   task automatic test_addr_err();
      int y, lat, e;
      cfg_we = 1; cfg_addr = ADDR_W'(10); cfg_data = 16'd999; in_valid = 1; in_data = 16'd55;
      #1;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL cfg_priority_ready: got %b want 0", in_ready); else n_pass++;
      @(negedge clk);
      cfg_we = 0; in_valid = 0;
      n_checks++; if (cfg_err !== 1'b1) $display("FAIL addr_err: got %b want 1", cfg_err); else n_pass++;
      cfg_write(9, 0);
      n_checks++; if (cfg_err !== 1'b0) $display("FAIL addr_ok_no_err: got %b want 0", cfg_err); else n_pass++;
      e = model_step(55);
      run_sample(55, 0, 0, y, lat);
      n_checks++; if (y !== e) $display("FAIL addr_err_readback: got %0d want %0d", y, e); else n_pass++;
   endtask

   task automatic test_backpressure();
      int x1 = rand_sample();
      int x2 = rand_sample();
      int e1, e2, lat;
      logic [DATA_W-1:0] e16;
      cfg_write(1, 3000);
      cfg_write(3, -2000);
      e1 = model_step(x1);
      e16 = DATA_W'(e1);
      start_sample(x1, 0);
      wait_out(lat);
      in_valid = 1; in_data = DATA_W'(x2);
      for (int c = 0; c < 20; c++) begin
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== e16 || in_ready !== 1'b0)
            $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b want valid=1 data=%h ready=0",
                     c, out_valid, out_data, in_ready, e16);
         else n_pass++;
         @(negedge clk);
      end
      out_ready = 1;
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else n_pass++;
      @(negedge clk);
      out_ready = 0; in_valid = 0; in_data = '0;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_single_handshake: got %b want 0", out_valid); else n_pass++;
      e2 = model_step(x2);
      lat = 0;
      while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
      n_checks++; if (lat !== LAT) $display("FAIL bp_next_latency: got %0d want %0d", lat, LAT); else n_pass++;
      n_checks++; if (int'($signed(out_data)) !== e2) $display("FAIL bp_next_data: got %0d want %0d", $signed(out_data), e2); else n_pass++;
      out_ready = 1; @(negedge clk); out_ready = 0;
   endtask

   task automatic test_back_to_back();
      int xs [3];
      int hs_cyc [$];
      int outs [$];
      int idx = 0;
      int c = 0;
      int e, got;
      bit hs;
      foreach (xs[i]) xs[i] = rand_sample();
      in_valid = 1; in_data = DATA_W'(xs[0]); out_ready = 1;
      while (outs.size() < 3 && c < 200) begin
         #1;
         hs = in_valid && in_ready;
         if (out_valid) outs.push_back(int'($signed(out_data)));
         if (hs) hs_cyc.push_back(c);
         @(negedge clk);
         c++;
         if (hs) begin
            idx++;
            if (idx < 3) in_data = DATA_W'(xs[idx]);
            else begin in_valid = 0; in_data = '0; end
         end
      end
      in_valid = 0; out_ready = 0;
      n_checks++; if (outs.size() !== 3) $display("FAIL b2b_count: got %0d want 3", outs.size()); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         e = model_step(xs[i]);
         got = (i < outs.size()) ? outs[i] : 99999;
         n_checks++; if (got !== e) $display("FAIL b2b_data[%0d]: got %0d want %0d", i, got, e); else n_pass++;
      end
      n_checks++;
      if (hs_cyc.size() !== 3 || (hs_cyc[1] - hs_cyc[0]) !== LAT + 1 || (hs_cyc[2] - hs_cyc[1]) !== LAT + 1)
         $display("FAIL b2b_interval: handshakes=%0d want 3 spaced %0d", hs_cyc.size(), LAT + 1);
      else n_pass++;
   endtask

   task automatic test_rst_mid();
      int x2 = rand_sample();
      int y, lat, e;
      bit seen = 0;
      cfg_write(0, 8192);
      start_sample(rand_sample(), 0);
      repeat (3) @(negedge clk);
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      model_reset();
      repeat (30) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      n_checks++; if (seen !== 1'b0) $display("FAIL rst_mid_no_output: got %b want 0", seen); else n_pass++;
      e = model_step(x2);
      run_sample(x2, 0, 0, y, lat);
      n_checks++; if (y !== e) $display("FAIL rst_mid_next: got %0d want %0d", y, e); else n_pass++;
      n_checks++; if (y !== x2) $display("FAIL rst_mid_identity: got %0d want %0d", y, x2); else n_pass++;
   endtask

   task automatic test_impulse();
      int cf [5] = '{4096, 0, -4096, -16384, 8192};
      int y, lat, e;
      apply_reset();
      foreach (cf[k]) cfg_write(k, cf[k]);
      for (int n = 0; n < 8; n++) begin
         e = model_step((n == 0) ? 16384 : 0);
         run_sample((n == 0) ? 16384 : 0, 0, 0, y, lat);
         n_checks++; if (y !== e) $display("FAIL impulse[%0d]: got %0d want %0d", n, y, e); else n_pass++;
      end
   endtask

   task automatic test_saturation();
      int y, lat, e;
      apply_reset();
      cfg_write(0, 32767);
      e = model_step(20000);
      run_sample(20000, 0, 0, y, lat);
      n_checks++; if (y !== e) $display("FAIL sat_data: got %0d want %0d", y, e); else n_pass++;
`ifdef BPF_BIQUAD_SAT_EN
      n_checks++; if (sat_flag !== 1'b1) $display("FAIL sat_flag_set: got %b want 1", sat_flag); else n_pass++;
      clr = 1; @(negedge clk); clr = 0;
      model_clear();
      n_checks++; if (sat_flag !== 1'b0) $display("FAIL sat_flag_clr: got %b want 0", sat_flag); else n_pass++;
`endif
   endtask

   task automatic test_random();
      int y, lat, e, x, stall;
      bit with_clr;
      apply_reset();
      for (int i = 0; i < NCOEF; i++) cfg_write(i, int'($urandom_range(0, 16383)) - 8192);
      for (int n = 0; n < 40; n++) begin
         x = rand_sample();
         with_clr = ($urandom_range(0, 7) == 0);
         stall = int'($urandom_range(0, 3));
         if (with_clr) model_clear();
         e = model_step(x);
         run_sample(x, with_clr, stall, y, lat);
         n_checks++; if (y !== e) $display("FAIL rand_data[%0d]: got %0d want %0d (x=%0d clr=%b)", n, y, e, x, with_clr); else n_pass++;
         n_checks++; if (lat !== LAT) $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, LAT); else n_pass++;
      end
`ifdef BPF_BIQUAD_SAT_EN
      n_checks++; if (sat_flag !== m_sat) $display("FAIL rand_sat_flag: got %b want %b", sat_flag, m_sat); else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_cfg_busy();
      test_addr_err();
      test_backpressure();
      test_back_to_back();
      test_rst_mid();
      test_impulse();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
